// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired fetch/decode/execute control unit for the bus-based datapath
// clk, clr        : clock (rising edge), asynchronous active-high reset
// ir, mem_ready   : IR contents from the datapath, memory read-data-valid handshake
// Rin, Rout       : one-hot register write enables / bus drives
// PCin..Read      : datapath strobes; AND, OR, NEG: ALU op selects
// run, illegal    : executing flag, one-cycle undefined-opcode pulse
// instr_count     : retired instruction count (wraps)
module ctrl_sequencer #(
    parameter logic [4:0] OPC_AND  = 5'b00101,
    parameter logic [4:0] OPC_OR   = 5'b00110,
    parameter logic [4:0] OPC_NEG  = 5'b10001,
    parameter logic [4:0] OPC_NOP  = 5'b11010,
    parameter logic [4:0] OPC_HALT = 5'b11011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        IncPC,
    output logic        Read,
    output logic        AND,
    output logic        OR,
    output logic        NEG,
    output logic        run,
    output logic        illegal,
    output logic [15:0] instr_count
);
    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        is_and, is_or, is_neg, is_nop, is_halt, is_logic;
    logic        unused_ir;
    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign is_and    = op == OPC_AND;
    assign is_or     = op == OPC_OR;
    assign is_neg    = op == OPC_NEG;
    assign is_nop    = op == OPC_NOP;
    assign is_halt   = op == OPC_HALT;
    assign is_logic  = is_and | is_or;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2:    state_d = S_T3;
            S_T3: begin
                state_d = is_logic ? S_T4 : is_neg ? S_T5 : is_halt ? S_HALT : S_T0;
                // NOP retires here; HALT counts once on its way into S_HALT
                cnt_d   = (is_nop | is_halt) ? cnt_q + 16'd1 : cnt_q;
            end
            S_T4:    state_d = S_T5;
            S_T5: begin
                state_d = S_T0;
                cnt_d   = cnt_q + 16'd1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign PCout       = state_q == S_T0;
    assign MARin       = state_q == S_T0;
    assign IncPC       = state_q == S_T0;
    assign Zin         = state_q == S_T0 || (state_q == S_T3 && is_neg) || state_q == S_T4;
    assign Zlowout     = state_q == S_T1 || state_q == S_T5;
    assign PCin        = state_q == S_T1;
    assign Read        = state_q == S_T1;
    assign MDRin       = state_q == S_T1 && mem_ready;
    assign MDRout      = state_q == S_T2;
    assign IRin        = state_q == S_T2;
    assign Yin         = state_q == S_T3 && is_logic;
    assign NEG         = state_q == S_T3 && is_neg;
    assign AND         = state_q == S_T4 && is_and;
    assign OR          = state_q == S_T4 && is_or;
    assign illegal     = state_q == S_T3 && !(is_logic | is_neg | is_nop | is_halt);
    assign Rout        = (state_q == S_T3 && (is_logic | is_neg)) ? 16'd1 << rb :
                         state_q == S_T4 ? 16'd1 << rc : 16'd0;
    assign Rin         = state_q == S_T5 ? 16'd1 << ra : 16'd0;
    assign run         = state_q != S_IDLE && state_q != S_HALT;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed and random instruction streams checked against a per-instruction cycle-list model
module tb_ctrl_sequencer;
    typedef struct packed {
        logic [15:0] rin, rout;
        logic pcin, pcout, irin, yin, zin, marin, mdrin, mdrout, zlowout, incpc, read, and_, or_, neg, run, illegal;
    } ctl_t;
    typedef struct {
        logic  mr;
        ctl_t  e;
        string tag;
    } step_t;
    localparam logic [4:0] OP_AND = 5'b00101, OP_OR = 5'b00110, OP_NEG = 5'b10001, OP_NOP = 5'b11010, OP_HALT = 5'b11011;
    logic        clk = 0, clr = 1, mem_ready = 0;
    logic [31:0] ir = '0;
    logic [15:0] Rin, Rout, instr_count;
    logic        PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, Zlowout, IncPC, Read, AND, OR, NEG, run, illegal;
    ctl_t        obs;
    step_t       seq[$];
    int          n_chk = 0, n_fail = 0;
    logic [15:0] cnt_exp = '0;
    ctrl_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Zlowout(Zlowout), .IncPC(IncPC), .Read(Read),
        .AND(AND), .OR(OR), .NEG(NEG), .run(run), .illegal(illegal), .instr_count(instr_count)
    );
    always #5 clk = ~clk;
    assign obs = {Rin, Rout, PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, Zlowout, IncPC, Read, AND, OR, NEG, run, illegal};
    function automatic bit retires(input logic [4:0] op);
        return op == OP_AND || op == OP_OR || op == OP_NEG || op == OP_NOP || op == OP_HALT;
    endfunction
    task automatic chk_w(input string tag, input ctl_t o, input ctl_t e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    task automatic chk_c(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask
    task automatic push(input logic mr, input ctl_t e, input string tag);
        step_t s;
        s.mr = mr; s.e = e; s.tag = tag;
        seq.push_back(s);
    endtask
    // expected control words, one per clock, for an instruction starting at T0 with w memory waits
    task automatic plan(input logic [31:0] instr, input int w);
        ctl_t c;
        logic [4:0] op = instr[31:27];
        int ra = int'(instr[26:23]), rb = int'(instr[22:19]), rc = int'(instr[18:15]);
        seq.delete();
        c = '0; c.run = 1; c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1;
        push(1'($urandom_range(0, 1)), c, "fetch_t0");
        c = '0; c.run = 1; c.zlowout = 1; c.pcin = 1; c.read = 1;
        for (int i = 0; i < w; i++) push(0, c, "fetch_wait");
        c.mdrin = 1;
        push(1, c, "fetch_ready");
        c = '0; c.run = 1; c.mdrout = 1; c.irin = 1;
        push(1'($urandom_range(0, 1)), c, "fetch_t2");
        c = '0; c.run = 1;
        if (op == OP_AND || op == OP_OR) begin c.rout[rb] = 1; c.yin = 1; end
        else if (op == OP_NEG) begin c.rout[rb] = 1; c.neg = 1; c.zin = 1; end
        else if (!retires(op)) c.illegal = 1;
        push(1'($urandom_range(0, 1)), c, "decode_t3");
        if (op == OP_AND || op == OP_OR) begin
            c = '0; c.run = 1; c.rout[rc] = 1; c.zin = 1; c.and_ = op == OP_AND; c.or_ = op == OP_OR;
            push(1'($urandom_range(0, 1)), c, "alu_t4");
        end
        if (op == OP_AND || op == OP_OR || op == OP_NEG) begin
            c = '0; c.run = 1; c.zlowout = 1; c.rin[ra] = 1;
            push(1'($urandom_range(0, 1)), c, "writeback_t5");
        end
    endtask
    task automatic execute(input logic [31:0] instr, input int n);
        ir = instr;
        for (int i = 0; i < n; i++) begin
            mem_ready = seq[i].mr;
            @(negedge clk);
            chk_w(seq[i].tag, obs, seq[i].e);
            @(posedge clk);
            #1;
        end
        if (n == seq.size()) begin
            if (retires(instr[31:27])) cnt_exp++;
            chk_c("instr_count", instr_count, cnt_exp);
        end
    endtask
    task automatic run_instr(input logic [31:0] instr, input int w);
        plan(instr, w);
        execute(instr, seq.size());
    endtask
    task automatic reset_pulse();
        clr = 1;
        #2;
        chk_w("reset_outputs", obs, '0);
        chk_c("reset_count", instr_count, 16'd0);
        cnt_exp = '0;
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_w("reset_hold", obs, '0);
            chk_c("reset_hold_count", instr_count, 16'd0);
        end
        clr = 0;
        @(posedge clk);
        #1;
        run_instr(32'h2A200000, 0);
        run_instr(32'h88980000, 4);
        run_instr(32'hF8000000, 0);
        run_instr(32'hD8000000, 0);
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_w("halted", obs, '0);
            chk_c("halted_count", instr_count, cnt_exp);
            @(posedge clk);
            #1;
        end
        reset_pulse();
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0: op = OP_AND;
                1: op = OP_OR;
                2: op = OP_NEG;
                3: op = OP_NOP;
                default: begin
                    op = 5'($urandom_range(0, 31));
                    while (retires(op)) op = 5'($urandom_range(0, 31));
                end
            endcase
            instr = {op, 27'($urandom)};
            run_instr(instr, int'($urandom_range(0, 3)));
        end
        instr = {OP_OR, 27'($urandom)};
        plan(instr, 1);
        execute(instr, 5);
        #2;
        clr = 1;
        #1;
        chk_w("clr_in_t4", obs, '0);
        chk_c("clr_in_t4_count", instr_count, 16'd0);
        cnt_exp = '0;
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
        run_instr({OP_NOP, 27'($urandom)}, 2);
        run_instr({OP_AND, 27'($urandom)}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
